// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder: decodes MDC/MDIO frames against a 32x16 PHY register
// file and drives read data back on MDIO. All protocol action happens on MDC rises.
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [31:0] PHY_ID   = 32'h001CC915,
  parameter int unsigned PRE_MIN  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        link_up,
  input  logic [1:0]  speed,
  output logic        wr_stb,
  output logic [4:0]  wr_reg,
  output logic [15:0] wr_data,
  output logic        frame_err
);

  typedef enum logic [2:0] {S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA} state_t;

  localparam logic [15:0] BMCR_DEFAULT = 16'h1140;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [1:0]  mdc_sync, mdio_sync;
  logic        mdc_prev;
  logic        rise, bit_in;
  logic [5:0]  pre_cnt;
  logic        op_hi, is_read;
  logic [4:0]  phy_sh, reg_sh;
  logic [15:0] data_sh;
  logic [15:0] regs [32];
  logic [4:0]  rd_addr;
  logic [15:0] rd_val;
  logic        phy_match, bad_frame, commit;
  logic [15:0] commit_data;

  // Sync flops reset to 1 so a high MDC at reset release is not seen as a rise.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdc_sync  <= 2'b11;
      mdc_prev  <= 1'b1;
      mdio_sync <= 2'b11;
    end else begin
      mdc_sync  <= {mdc_sync[0], mdc};
      mdc_prev  <= mdc_sync[1];
      mdio_sync <= {mdio_sync[0], mdio_i};
    end
  end

  assign rise        = mdc_sync[1] & ~mdc_prev;
  assign bit_in      = mdio_sync[1];
  assign phy_match   = (phy_sh == PHY_ADDR);
  assign rd_addr     = {reg_sh[3:0], bit_in};
  assign commit_data = {data_sh[14:0], bit_in};
  assign commit      = rise && (state == S_DATA) && (cnt == 4'd15) && !is_read;
  assign bad_frame   = rise && (((state == S_ST) && !bit_in) ||
                                ((state == S_OP) && (cnt == 4'd1) && (op_hi == bit_in)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (rise) begin
      case (state)
        S_IDLE:  if (!bit_in && (32'(pre_cnt) >= PRE_MIN)) begin
                   state_nxt = S_ST;
                   cnt_nxt   = '0;
                 end
        S_ST:    state_nxt = bit_in ? S_OP : S_IDLE;
        S_OP:    if (cnt == 4'd0) cnt_nxt = 4'd1;
                 else begin
                   cnt_nxt   = '0;
                   state_nxt = (op_hi ^ bit_in) ? S_PHYAD : S_IDLE;
                 end
        S_PHYAD: if (cnt == 4'd4) begin
                   cnt_nxt   = '0;
                   state_nxt = S_REGAD;
                 end else cnt_nxt = cnt + 4'd1;
        S_REGAD: if (cnt == 4'd4) begin
                   cnt_nxt   = '0;
                   state_nxt = phy_match ? S_TA : S_IDLE;
                 end else cnt_nxt = cnt + 4'd1;
        S_TA:    if (cnt == 4'd1) begin
                   cnt_nxt   = '0;
                   state_nxt = S_DATA;
                 end else cnt_nxt = cnt + 4'd1;
        S_DATA:  if (cnt == 4'd15) begin
                   cnt_nxt   = '0;
                   state_nxt = S_IDLE;
                 end else cnt_nxt = cnt + 4'd1;
        default: begin
                   cnt_nxt   = '0;
                   state_nxt = S_IDLE;
                 end
      endcase
    end
  end

  always_comb begin
    rd_val = regs[rd_addr];
    case (rd_addr)
      5'd0:    rd_val = {1'b0, regs[0][14:0]};
      5'd1:    rd_val = {13'h0F24, link_up, 2'b01};
      5'd2:    rd_val = PHY_ID[31:16];
      5'd3:    rd_val = PHY_ID[15:0];
      5'd17:   rd_val = {speed, 1'b1, 2'b00, link_up, 10'h000};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt   <= '0;
      op_hi     <= 1'b0;
      is_read   <= 1'b0;
      phy_sh    <= '0;
      reg_sh    <= '0;
      data_sh   <= '0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
      wr_stb    <= 1'b0;
      wr_reg    <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_stb    <= commit;
      frame_err <= bad_frame;
      if (commit) begin
        wr_reg  <= reg_sh;
        wr_data <= commit_data;
      end
      if (rise) begin
        case (state)
          S_IDLE:  pre_cnt <= !bit_in ? 6'd0 : (pre_cnt == 6'd63) ? pre_cnt : pre_cnt + 6'd1;
          S_OP:    if (cnt == 4'd0) op_hi <= bit_in;
                   else is_read <= op_hi;
          S_PHYAD: phy_sh <= {phy_sh[3:0], bit_in};
          S_REGAD: begin
                     reg_sh <= rd_addr;
                     // Snapshot here so status inputs cannot tear a value mid-shift.
                     if ((cnt == 4'd4) && is_read && phy_match) data_sh <= rd_val;
                   end
          S_TA:    if (is_read) begin
                     if (cnt == 4'd0) begin
                       mdio_oe <= 1'b1;
                       mdio_o  <= 1'b0;
                     end else begin
                       mdio_o  <= data_sh[15];
                       data_sh <= {data_sh[14:0], 1'b0};
                     end
                   end
          S_DATA:  if (!is_read) data_sh <= commit_data;
                   else if (cnt == 4'd15) begin
                     mdio_oe <= 1'b0;
                     mdio_o  <= 1'b1;
                   end else begin
                     mdio_o  <= data_sh[15];
                     data_sh <= {data_sh[14:0], 1'b0};
                   end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the register array is reset explicitly because every R/W register has a defined default.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? BMCR_DEFAULT : 16'h0000;
    end else if (commit) begin
      if ((reg_sh == 5'd0) && commit_data[15]) begin
        for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? BMCR_DEFAULT : 16'h0000;
      end else if (!(reg_sh inside {5'd1, 5'd2, 5'd3, 5'd17})) begin
        regs[reg_sh] <= commit_data;
      end
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: acts as MDIO initiator and checks reads/writes against
// a register-map model of the PHY.
module tb_mdio_responder;

  localparam logic [31:0] PHY_ID = 32'h001CC915;

  logic        clk = 1'b0;
  logic        rst;
  logic        mdc;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_oe;
  logic        link_up;
  logic [1:0]  speed;
  logic        wr_stb;
  logic [4:0]  wr_reg;
  logic [15:0] wr_data;
  logic        frame_err;
  logic        tb_drv;
  logic        mdio_line;

  int n_checks = 0;
  int n_fail   = 0;
  int stb_cnt  = 0;
  int err_cnt  = 0;
  logic [15:0] model [32];

  mdio_responder #(.PHY_ADDR(5'd1), .PHY_ID(PHY_ID), .PRE_MIN(32)) dut (
    .clk(clk), .rst(rst), .mdc(mdc), .mdio_i(mdio_i), .mdio_o(mdio_o),
    .mdio_oe(mdio_oe), .link_up(link_up), .speed(speed), .wr_stb(wr_stb),
    .wr_reg(wr_reg), .wr_data(wr_data), .frame_err(frame_err)
  );

  // Open-drain style bus with pull-up: the PHY wins when it enables its driver.
  assign mdio_line = mdio_oe ? mdio_o : tb_drv;
  assign mdio_i    = mdio_line;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_stb)    stb_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) model[i] = 16'h0000;
    model[0] = 16'h1140;
  endfunction

  function automatic void model_write(input int a, input logic [15:0] d);
    if (a == 0 && d[15]) model_reset();
    else if (a != 1 && a != 2 && a != 3 && a != 17) model[a] = d;
  endfunction

  function automatic logic [15:0] model_read(input int a);
    case (a)
      0:       return model[0] & 16'h7FFF;
      1:       return {13'h0F24, link_up, 2'b01};
      2:       return PHY_ID[31:16];
      3:       return PHY_ID[15:0];
      17:      return {speed, 1'b1, 2'b00, link_up, 10'h000};
      default: return model[a];
    endcase
  endfunction

  // One MDC period: drive during the low half, sample the line just before the rise.
  task automatic mdc_bit(input logic b, output logic line_s, output logic oe_s);
    mdc    = 1'b0;
    tb_drv = b;
    #50;
    line_s = mdio_line;
    oe_s   = mdio_oe;
    mdc    = 1'b1;
    #50;
  endtask

  task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [15:0] wd, input int rst_at,
                       output logic [15:0] rdata, output int oe_cnt, output logic ta2);
    logic [31:0] hdr;
    logic        ln, oe, is_rd;
    is_rd  = (op == 2'b10);
    oe_cnt = 0;
    rdata  = '0;
    ta2    = 1'b1;
    mdc_bit(1'b0, ln, oe);
    if (oe) oe_cnt++;
    repeat (pre) begin
      mdc_bit(1'b1, ln, oe);
      if (oe) oe_cnt++;
    end
    hdr = {2'b01, op, phy, ra, (is_rd ? 2'b11 : 2'b10), (is_rd ? 16'hFFFF : wd)};
    for (int k = 1; k <= 32; k++) begin
      mdc_bit(hdr[32-k], ln, oe);
      if (oe) oe_cnt++;
      if (k == 16) ta2 = ln;
      if (k >= 17) rdata[32-k] = ln;
      if (k == rst_at) begin
        check("pre_rst_oe", {31'b0, mdio_oe}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_oe_async", {31'b0, mdio_oe}, 32'd0);
        check("rst_o_idle", {31'b0, mdio_o}, 32'd1);
        #9;
        rst = 1'b0;
      end
    end
    repeat (2) begin
      mdc_bit(1'b1, ln, oe);
      if (oe) oe_cnt++;
    end
  endtask

  task automatic do_read(input string tag, input logic [4:0] ra);
    logic [15:0] rd;
    int          oc;
    logic        t2;
    frame(32, 2'b10, 5'd1, ra, 16'h0, -1, rd, oc, t2);
    check({tag, "_data"}, {16'h0, rd}, {16'h0, model_read(ra)});
    check({tag, "_oe_len"}, oc, 32'd17);
  endtask

  task automatic do_write(input string tag, input logic [4:0] ra, input logic [15:0] wd);
    logic [15:0] rd;
    int          oc, s0;
    logic        t2;
    s0 = stb_cnt;
    frame(32, 2'b01, 5'd1, ra, wd, -1, rd, oc, t2);
    model_write(ra, wd);
    check({tag, "_stb"}, stb_cnt - s0, 32'd1);
    check({tag, "_reg"}, {27'h0, wr_reg}, {27'h0, ra});
    check({tag, "_wdata"}, {16'h0, wr_data}, {16'h0, wd});
    check({tag, "_oe"}, oc, 32'd0);
  endtask

  initial begin
    logic [15:0] rd;
    int          oc, s0, e0;
    logic        t2;
    logic [4:0]  ra;
    rst = 1'b1; mdc = 1'b0; tb_drv = 1'b1; link_up = 1'b0; speed = 2'b00;
    model_reset();
    #23;
    check("rst_oe", {31'b0, mdio_oe}, 32'd0);
    check("rst_o", {31'b0, mdio_o}, 32'd1);
    check("rst_wr_stb", {31'b0, wr_stb}, 32'd0);
    check("rst_frame_err", {31'b0, frame_err}, 32'd0);
    check("rst_wr_reg", {27'h0, wr_reg}, 32'd0);
    check("rst_wr_data", {16'h0, wr_data}, 32'd0);
    #20 rst = 1'b0;
    #40;

    frame(32, 2'b10, 5'd1, 5'd2, 16'h0, -1, rd, oc, t2);
    check("id_hi_data", {16'h0, rd}, 32'h001C);
    check("id_hi_oe_len", oc, 32'd17);
    check("id_hi_ta2", {31'b0, t2}, 32'd0);
    do_read("id_lo", 5'd3);

    do_write("wr4", 5'd4, 16'h01E1);
    do_read("rd4", 5'd4);

    s0 = stb_cnt;
    frame(32, 2'b10, 5'd2, 5'd2, 16'h0, -1, rd, oc, t2);
    check("phyad_mismatch_oe", oc, 32'd0);
    frame(31, 2'b10, 5'd1, 5'd2, 16'h0, -1, rd, oc, t2);
    check("short_pre_oe", oc, 32'd0);
    check("filter_no_stb", stb_cnt - s0, 32'd0);

    e0 = err_cnt;
    frame(32, 2'b11, 5'd1, 5'd4, 16'h0, -1, rd, oc, t2);
    check("bad_op_err", err_cnt - e0, 32'd1);
    check("bad_op_oe", oc, 32'd0);
    do_read("after_bad_op", 5'd4);

    link_up = 1'b1; speed = 2'b10;
    frame(32, 2'b10, 5'd1, 5'd17, 16'h0, -1, rd, oc, t2);
    check("physr_a400", {16'h0, rd}, 32'hA400);
    do_read("bmsr", 5'd1);
    do_write("wr4b", 5'd4, 16'h1234);
    do_write("bmcr_rst", 5'd0, 16'h8000);
    frame(32, 2'b10, 5'd1, 5'd0, 16'h0, -1, rd, oc, t2);
    check("bmcr_default", {16'h0, rd}, 32'h1140);
    frame(32, 2'b10, 5'd1, 5'd4, 16'h0, -1, rd, oc, t2);
    check("reg4_cleared", {16'h0, rd}, 32'h0000);
    do_write("wr_ro", 5'd2, 16'hBEEF);
    do_read("ro_kept", 5'd2);

    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 5))
        0:       ra = 5'd0;
        1:       ra = 5'd1;
        2:       ra = 5'd17;
        default: ra = 5'($urandom_range(4, 31));
      endcase
      link_up = 1'($urandom);
      speed   = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 0) do_write("rnd_wr", ra, 16'($urandom));
      else do_read("rnd_rd", ra);
    end

    do_write("pre_rst_wr", 5'd5, 16'h5A5A);
    frame(32, 2'b10, 5'd1, 5'd3, 16'h0, 21, rd, oc, t2);
    model_reset();
    do_read("post_rst_id", 5'd3);
    do_read("post_rst_reg5", 5'd5);
    do_read("post_rst_bmcr", 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdio_responder.md
# mdio_responder

PHY-side (responder) end of the IEEE 802.3 clause-22 MDIO management interface driven by the `mdc` management controller. It decodes serial MDC/MDIO frames, holds a 32×16 PHY register file, and drives read data back on MDIO. It stands in for the RTL8211EG register set in the MAC loopback and bring-up build and in the verification bench, and it feeds the gigabit-mode/link status path.

## Interface
Parameters:
- `PHY_ADDR`, 5'd1: PHY address this responder answers to.
- `PHY_ID`, 32'h001CC915: value of registers 2 (bits 31:16) and 3 (bits 15:0).
- `PRE_MIN`, 32: consecutive 1 bits needed before ST is accepted (1..63).

Ports:
- `clk`  in  1: system clock, must be ≥ 8× the MDC frequency.
- `rst`  in  1: asynchronous reset, active-high.
- `mdc`  in  1: management clock from the initiator (asynchronous to `clk`).
- `mdio_i`  in  1: MDIO line as seen at the pad.
- `mdio_o`  out  1: MDIO drive value.
- `mdio_oe`  out  1: MDIO output enable. The pad is tri-stated when this is 0.
- `link_up`  in  1: link status, reflected in registers 1 and 17.
- `speed`  in  2: 2'b00 = 10, 2'b01 = 100, 2'b10 = 1000 Mb/s. Reflected in register 17.
- `wr_stb`  out  1: one-`clk` pulse for each completed write frame addressed to this PHY.
- `wr_reg`  out  5: register address of the last write.
- `wr_data`  out  16: data of the last write.
- `frame_err`  out  1: one-`clk` pulse on a bad ST or OP field.

## Operation
- **Input synchronisation.**
  - `mdc` and `mdio_i` each pass through a 2-flop synchroniser.
  - `rise` = synchronised `mdc` is 1 and its previous value was 0.
  - All protocol action happens only in `clk` cycles where `rise`=1. MDIO is sampled from its synchroniser on those cycles.
- **State machine** (states and their bit counts):
  - IDLE: counts consecutive 1s in `pre_cnt`, saturating at 63. A 0 with `pre_cnt`≥`PRE_MIN` moves to ST (the sampled 0 is the first ST bit). A 0 with `pre_cnt`<`PRE_MIN` clears `pre_cnt` and stays in IDLE.
  - ST: 1 bit, must be 1 (completes ST=01). Otherwise pulse `frame_err` and go to IDLE.
  - OP: 2 bits. 10 = read, 01 = write. 00 or 11 pulses `frame_err` and goes to IDLE.
  - PHYAD: 5 bits, MSB first.
  - REGAD: 5 bits, MSB first. On the last bit, a PHYAD mismatch goes to IDLE with no drive and no write.
  - TA: 2 bits.
  - DATA: 16 bits, MSB first, then IDLE.
- **Read frames.**
  - On the last REGAD bit, snapshot the addressed register into the shift register. Later changes to `link_up`/`speed` do not tear the value being shifted.
  - At the rise ending TA bit 1, set `mdio_oe`=1 and `mdio_o`=0.
  - At each following rise, present the next data bit: D15 first, D0 presented at the rise ending DATA bit 15.
  - At the rise ending D0, release: `mdio_oe`=0.
- **Write frames.**
  - TA bits are ignored.
  - The 16th data bit completes the write: the register updates in the next `clk`, and `wr_stb`, `wr_reg` and `wr_data` update in the same cycle.
  - Writes to read-only registers pulse `wr_stb` but leave storage unchanged.
- **Register map.** All other registers are R/W with reset value 0.
  - Reg 0 (BMCR): R/W, reset 16'h1140. Bit 15 is self-clearing: writing 1 reloads every R/W register with its default, and bit 15 always reads 0.
  - Reg 1 (BMSR): RO, `{13'h0F24, link_up, 2'b01}`.
  - Regs 2/3: RO, from `PHY_ID`.
  - Reg 17 (PHYSR): RO, `{speed, 1'b1, 2'b00, link_up, 10'h000}`.
- **Reset.** `rst` forces:
  - IDLE with `pre_cnt`=0;
  - `mdio_oe`=0, `mdio_o`=1;
  - `wr_stb`=0, `frame_err`=0, `wr_reg`=0, `wr_data`=0;
  - all R/W registers to their defaults.
- **Mid-frame behaviour.**
  - Reset mid-frame releases MDIO in the same cycle (asynchronously).
  - There is no MDC timeout: a stalled MDC freezes the state.

## Timing
- `rise` occurs 3 `clk` after the MDC pad edge (2 synchroniser stages plus the edge register). `mdio_o`/`mdio_oe` change at that point plus 1 `clk`, i.e. ≤ 4 `clk` after the pad edge. The clock ratio of ≥ 8 keeps this within the initiator's next rising-edge sample.
- A full frame is 32 + 32 = 64 MDC periods. Back-to-back frames with a 32-bit preamble are supported.
- `wr_stb` fires 1 `clk` after the `rise` that carries D0.
- `frame_err` fires 1 `clk` after the offending `rise`.

## Test plan
- **Read PHY ID.**
  - Stimulus: 32×1 preamble, ST 01, OP 10, PHYAD 1, REGAD 2.
  - Required: `mdio_oe` goes high for exactly 17 MDC periods; TA bit 2 reads 0; data reads 16'h001C. REGAD 3 reads 16'hC915.
- **Write then read back.**
  - Stimulus: write 16'h01E1 to reg 4, then read reg 4.
  - Required: `wr_stb` is one pulse with `wr_reg`=4 and `wr_data`=16'h01E1; the readback returns 16'h01E1.
- **Address and preamble filtering.**
  - Stimulus: a read with PHYAD=2; separately, a read to PHYAD 1 with only 31 preamble ones.
  - Required: `mdio_oe` stays 0 throughout, with no `wr_stb`, in both cases.
- **Bad opcode.**
  - Stimulus: OP=11.
  - Required: exactly one `frame_err` pulse. A correct read that follows is serviced normally.
- **Status and BMCR reset.**
  - Stimulus: `link_up`=1, `speed`=2'b10, read reg 17; then write reg 4 to 16'h1234, write reg 0 with 16'h8000, and read regs 0 and 4.
  - Required: reg 17 reads 16'hA400; reg 0 reads 16'h1140; reg 4 reads 0.
- **Reset mid-read.**
  - Stimulus: assert `rst` during DATA bit 5.
  - Required: `mdio_oe`=0 immediately. The next full read frame is serviced correctly.
